// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator front end.
package falafel_pkg;

    localparam int DATA_W            = 16;
    localparam int BLOCK_HEADER_SIZE = 8;

    // Largest alloc size whose header still fits in the address space.
    localparam logic [DATA_W-1:0] MAX_ALLOC_SIZE =
        {DATA_W{1'b1}} - DATA_W'(BLOCK_HEADER_SIZE);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              is_alloc;
        logic [DATA_W-1:0] size;
        logic [DATA_W-1:0] addr;
    } alloc_cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic              err;
    } alloc_rsp_t;

    // Malformed commands are answered locally and never reach the core.
    function automatic logic cmd_rejected(input alloc_cmd_t cmd);
        if (cmd.is_alloc) begin
            return (cmd.size == '0) || (cmd.size > MAX_ALLOC_SIZE);
        end
        return cmd.addr == '0;
    endfunction

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational rotate-priority picker: first asserted req at or after ptr,
// scanning upward modulo NUM_REQ. Produces a one-hot grant and its index.
module falafel_rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W:0] pos;

    // Scan offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        pos     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            if (req[pos[IDX_W-1:0]]) begin
                gnt                  = '0;
                gnt[pos[IDX_W-1:0]]  = 1'b1;
                gnt_idx              = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/falafel_arbiter.sv
// Round-robin front end sharing one falafel_core among NUM_REQ requesters.
// Commands are serialised one at a time: ARB -> ISSUE -> BUSY -> RESP, or
// ARB -> RESP directly for malformed commands.
// Optional watchdog: define FALAFEL_ARB_TIMEOUT_EN to abort ISSUE/BUSY after
// TIMEOUT_CYCLES with an error response.
module falafel_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = falafel_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0]             req_is_alloc_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_size_i,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [DATA_W-1:0]              rsp_addr_o,
    output logic                           rsp_err_o,
    output logic                           core_req_valid_o,
    output logic                           core_is_alloc_o,
    output logic [DATA_W-1:0]              core_size_o,
    output logic [DATA_W-1:0]              core_addr_o,
    input  logic                           core_ready_i,
    input  logic                           core_done_i,
    input  logic [DATA_W-1:0]              core_rsp_addr_i
);

    import falafel_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time parameter sanity; the command structs are sized by
    // the package, so the port width must agree with it.
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("falafel_arbiter: NUM_REQ must be 2..16");
    end
    if (DATA_W != falafel_pkg::DATA_W) begin : g_bad_data_w
        $error("falafel_arbiter: DATA_W must equal falafel_pkg::DATA_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("falafel_arbiter: TIMEOUT_CYCLES must be positive");
    end

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    alloc_cmd_t         cmd_q, cmd_d;
    alloc_rsp_t         rsp_q, rsp_d;
    alloc_cmd_t         win_cmd;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;

    falafel_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (req_valid_i),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Fields of the requester the picker would accept this cycle.
    always_comb begin
        win_cmd          = '0;
        win_cmd.is_alloc = req_is_alloc_i[gnt_idx];
        win_cmd.size     = req_size_i[gnt_idx];
        win_cmd.addr     = req_addr_i[gnt_idx];
    end

`ifdef FALAFEL_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d, wd_next;
    logic            wd_expired;

    // Expiry looks one count ahead so RESP starts exactly TIMEOUT_CYCLES
    // after ISSUE entry.
    always_comb begin
        wd_next    = wd_cnt_q + 1'b1;
        wd_expired = (wd_next == WD_W'(TIMEOUT_CYCLES));
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wd_cnt_q <= '0;
        else       wd_cnt_q <= wd_cnt_d;
    end
`endif

    // Next-state logic: arbitration, reject check, core handshake, result capture.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        rsp_d    = rsp_q;
`ifdef FALAFEL_ARB_TIMEOUT_EN
        wd_cnt_d = wd_cnt_q;
`endif
        case (state_q)
            ARB: begin
                if (|req_valid_i) begin
                    owner_d = gnt_idx;
                    cmd_d   = win_cmd;
                    if (cmd_rejected(win_cmd)) begin
                        rsp_d.addr = '0;
                        rsp_d.err  = 1'b1;
                        state_d    = RESP;
                    end else begin
                        rsp_d   = '0;
                        state_d = ISSUE;
`ifdef FALAFEL_ARB_TIMEOUT_EN
                        wd_cnt_d = '0;
`endif
                    end
                end
            end
            ISSUE: begin
`ifdef FALAFEL_ARB_TIMEOUT_EN
                wd_cnt_d = wd_next;
`endif
                if (core_ready_i) begin
                    state_d = BUSY;
                end
`ifdef FALAFEL_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    rsp_d.addr = '0;
                    rsp_d.err  = 1'b1;
                    state_d    = RESP;
                end
`endif
            end
            BUSY: begin
`ifdef FALAFEL_ARB_TIMEOUT_EN
                wd_cnt_d = wd_next;
`endif
                if (core_done_i) begin
                    // A free has no meaningful result address.
                    rsp_d.addr = cmd_q.is_alloc ? core_rsp_addr_i : '0;
                    rsp_d.err  = 1'b0;
                    state_d    = RESP;
                end
`ifdef FALAFEL_ARB_TIMEOUT_EN
                else if (wd_expired) begin
                    rsp_d.addr = '0;
                    rsp_d.err  = 1'b1;
                    state_d    = RESP;
                end
`endif
            end
            RESP: begin
                // The requester just served drops to lowest priority.
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d  = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // State and latched-command registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cmd_q    <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cmd_q    <= cmd_d;
            rsp_q    <= rsp_d;
        end
    end

    // Outputs decode from registers only; req_ready_o also sees req_valid_i.
    always_comb begin
        req_ready_o = (state_q == ARB) ? gnt : '0;
        rsp_valid_o = '0;
        if (state_q == RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
        rsp_addr_o       = (state_q == RESP) ? rsp_q.addr : '0;
        rsp_err_o        = (state_q == RESP) && rsp_q.err;
        core_req_valid_o = (state_q == ISSUE);
        core_is_alloc_o  = cmd_q.is_alloc;
        core_size_o      = cmd_q.size;
        core_addr_o      = cmd_q.addr;
    end

endmodule

// File: tb/tb_falafel_arbiter.sv
// Directed bench for falafel_arbiter with a behavioural core model and a
// response scoreboard.
module tb_falafel_arbiter;
    import falafel_pkg::*;

    localparam int NR = 4;
    localparam int DW = falafel_pkg::DATA_W;
    localparam int TO = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NR-1:0]              req_valid_i, req_is_alloc_i;
    logic [NR-1:0][DW-1:0]      req_size_i, req_addr_i;
    logic [NR-1:0]              req_ready_o, rsp_valid_o;
    logic [DW-1:0]              rsp_addr_o;
    logic                       rsp_err_o;
    logic                       core_req_valid_o, core_is_alloc_o;
    logic [DW-1:0]              core_size_o, core_addr_o;
    logic                       core_ready_i, core_done_i;
    logic [DW-1:0]              core_rsp_addr_i;

    falafel_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_is_alloc_i(req_is_alloc_i),
        .req_size_i(req_size_i), .req_addr_i(req_addr_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_addr_o(rsp_addr_o), .rsp_err_o(rsp_err_o),
        .core_req_valid_o(core_req_valid_o), .core_is_alloc_o(core_is_alloc_o),
        .core_size_o(core_size_o), .core_addr_o(core_addr_o),
        .core_ready_i(core_ready_i), .core_done_i(core_done_i),
        .core_rsp_addr_i(core_rsp_addr_i)
    );

    always #5 clk = ~clk;

    // kind: 0 = via core (1 cycle after done), 1 = reject (1 after accept),
    //       2 = watchdog (TO+1 after accept)
    typedef struct { int idx; logic [DW-1:0] addr; logic err; int kind; } exp_t;
    exp_t        sb[$];
    int          grant_log[$];
    logic [63:0] fwd_q[$];

    int tests = 0, fails = 0, cyc = 0, rsp_cnt = 0;
    int hs_cnt = 0, cvalid_cnt = 0, last_acc_cyc = 0, last_done_cyc = 0;
    int core_lat = 0, lat_cnt = 0, stall_left = 0;
    bit core_auto = 1'b1, busy_m = 1'b0, force_done = 1'b0, prev_cvalid = 1'b0;
    logic [DW-1:0] addr_base = '0, addr_step = '0;
    logic [63:0]   saved_cmd = '0;
    logic [NR-1:0] acc_seen = '0, sticky = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Requesters drop valid after the cycle they were accepted (unless sticky).
    always @(posedge clk) begin
        #1;
        req_valid_i = req_valid_i & ~(acc_seen & ~sticky);
    end

    // Monitor + scoreboard + core model, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [NR-1:0] acc;
        if (rsp_valid_o != '0) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_onehot", 64'(rsp_valid_o), 64'd1 << e.idx);
                check("rsp_addr", 64'(rsp_addr_o), 64'(e.addr));
                check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                case (e.kind)
                    0: check("rsp_lat_done", 64'(cyc), 64'(last_done_cyc + 1));
                    1: check("rsp_lat_rej", 64'(cyc), 64'(last_acc_cyc + 1));
                    default: check("rsp_lat_wd", 64'(cyc), 64'(last_acc_cyc + TO + 1));
                endcase
            end
        end
        if (core_req_valid_o) begin
            cvalid_cnt++;
            if (prev_cvalid)
                check("core_stable", {31'd0, core_is_alloc_o, core_size_o, core_addr_o}, saved_cmd);
            saved_cmd = {31'd0, core_is_alloc_o, core_size_o, core_addr_o};
        end
        prev_cvalid = core_req_valid_o;
        acc = req_ready_o & req_valid_i;
        if (acc != '0) begin
            check("ready_onehot", 64'($countones(req_ready_o)), 64'd1);
            for (int i = 0; i < NR; i++) if (acc[i]) grant_log.push_back(i);
            last_acc_cyc = cyc;
        end
        acc_seen = acc;
        core_ready_i = 1'b0;
        core_done_i  = 1'b0;
        if (force_done) begin
            core_done_i     = 1'b1;
            core_rsp_addr_i = 16'hDEAD;
            force_done      = 1'b0;
        end else if (core_auto) begin
            if (busy_m) begin
                if (lat_cnt == 0) begin
                    core_done_i     = 1'b1;
                    core_rsp_addr_i = addr_base;
                    addr_base       = addr_base + addr_step;
                    busy_m          = 1'b0;
                    last_done_cyc   = cyc;
                end else lat_cnt--;
            end else if (core_req_valid_o) begin
                if (stall_left > 0) stall_left--;
                else begin
                    core_ready_i = 1'b1;
                    hs_cnt++;
                    busy_m  = 1'b1;
                    lat_cnt = core_lat;
                    fwd_q.push_back({31'd0, core_is_alloc_o, core_size_o, core_addr_o});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic issue_req(input int i, input logic is_alloc, input logic [DW-1:0] size,
                             input logic [DW-1:0] addr);
        req_is_alloc_i[i] = is_alloc;
        req_size_i[i]     = size;
        req_addr_i[i]     = addr;
        req_valid_i[i]    = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic [DW-1:0] addr, input logic err, input int kind);
        exp_t e;
        e.idx = i; e.addr = addr; e.err = err; e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int n = 0; n < max; n++) begin
            if (sb.size() == 0 && req_valid_i == '0 && !busy_m) break;
            step();
        end
        check(tag, 64'(sb.size()), 64'd0);
        step(); step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready_o), 64'd0);
        check({tag, "_rspv"}, 64'(rsp_valid_o), 64'd0);
        check({tag, "_rspa"}, 64'(rsp_addr_o), 64'd0);
        check({tag, "_rspe"}, 64'(rsp_err_o), 64'd0);
        check({tag, "_corev"}, 64'(core_req_valid_o), 64'd0);
        check({tag, "_corecmd"}, {31'd0, core_is_alloc_o, core_size_o, core_addr_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0, cv0, rc0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid_i = '0; req_is_alloc_i = '0; req_size_i = '0; req_addr_i = '0;
        core_ready_i = 1'b0; core_done_i = 1'b0; core_rsp_addr_i = '0;
        step(); step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // Fairness: all four requesters hold valid; req3 issues a free.
        core_lat = 1; addr_base = 16'h0100; addr_step = 16'h0020;
        grant_log.delete();
        push_exp(0, 16'h0100, 1'b0, 0);
        push_exp(1, 16'h0120, 1'b0, 0);
        push_exp(2, 16'h0140, 1'b0, 0);
        push_exp(3, 16'h0000, 1'b0, 0);
        push_exp(0, 16'h0180, 1'b0, 0);
        sticky = 4'hF;
        for (int i = 0; i < 3; i++) issue_req(i, 1'b1, DW'(16 * (i + 1)), '0);
        issue_req(3, 1'b0, '0, 16'h0300);
        for (int n = 0; n < 300; n++) begin
            if (grant_log.size() >= 5) break;
            step();
        end
        req_valid_i = '0; sticky = '0;
        check("fair_count", 64'(grant_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("fair_order", 64'(grant_log[k]), 64'(exp_order[k]));
        wait_idle("fair_drain", 200);

        // Single alloc: req0 size 0x40, done 5 cycles after handshake, addr 0x10.
        core_lat = 4; addr_base = 16'h0010; addr_step = '0;
        fwd_q.delete();
        push_exp(0, 16'h0010, 1'b0, 0);
        issue_req(0, 1'b1, 16'h0040, '0);
        wait_idle("single_drain", 100);
        check("single_fwd_n", 64'(fwd_q.size()), 64'd1);
        if (fwd_q.size() > 0) check("single_fwd", fwd_q.pop_front(), {31'd0, 1'b1, 16'h0040, 16'h0000});

        // Rejects never reach the core; boundary size one above the limit too.
        cv0 = cvalid_cnt;
        push_exp(2, '0, 1'b1, 1);
        issue_req(2, 1'b1, '0, '0);
        wait_idle("rej_size0", 50);
        push_exp(1, '0, 1'b1, 1);
        issue_req(1, 1'b0, '0, '0);
        wait_idle("rej_addr0", 50);
        push_exp(3, '0, 1'b1, 1);
        issue_req(3, 1'b1, 16'hFFF8, '0);
        wait_idle("rej_big", 50);
        check("rej_no_core", 64'(cvalid_cnt), 64'(cv0));

        // Largest legal size goes through.
        core_lat = 0; addr_base = 16'h2000; fwd_q.delete();
        push_exp(3, 16'h2000, 1'b0, 0);
        issue_req(3, 1'b1, 16'hFFF7, '0);
        wait_idle("max_ok", 50);
        if (fwd_q.size() > 0) check("max_fwd", fwd_q.pop_front(), {31'd0, 1'b1, 16'hFFF7, 16'h0000});

        // Backpressure: core_ready low for 7 cycles in ISSUE.
        cv0 = cvalid_cnt; hs0 = hs_cnt; core_lat = 2; addr_base = 16'h0400;
        stall_left = 7;
        push_exp(1, 16'h0400, 1'b0, 0);
        issue_req(1, 1'b1, 16'h0080, '0);
        wait_idle("bp_drain", 100);
        check("bp_valid_cycles", 64'(cvalid_cnt - cv0), 64'd8);
        check("bp_handshakes", 64'(hs_cnt - hs0), 64'd1);

        // Mid-operation reset: pointer is 2 beforehand, must be 0 afterwards.
        hs0 = hs_cnt; rc0 = rsp_cnt; core_lat = 8;
        issue_req(2, 1'b1, 16'h0020, '0);
        for (int n = 0; n < 50; n++) begin
            if (hs_cnt != hs0) break;
            step();
        end
        check("mid_hs", 64'(hs_cnt - hs0), 64'd1);
        step(); step();
        rst = 1'b1;
        step();
        check_outputs_zero("midrst");
        rst = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (!busy_m) break;
            step();
        end
        step(); step(); step();
        check("midrst_no_rsp", 64'(rsp_cnt - rc0), 64'd0);
        core_lat = 1; addr_base = 16'h3000; addr_step = 16'h0010;
        grant_log.delete();
        push_exp(1, 16'h3000, 1'b0, 0);
        push_exp(3, 16'h3010, 1'b0, 0);
        req_is_alloc_i[1] = 1'b1; req_size_i[1] = 16'h0011;
        req_is_alloc_i[3] = 1'b1; req_size_i[3] = 16'h0033;
        req_valid_i = 4'b1010;
        wait_idle("ptr_drain", 100);
        check("ptr_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd1);

`ifdef FALAFEL_ARB_TIMEOUT_EN
        // Watchdog: core never answers; a late done is ignored.
        core_auto = 1'b0;
        push_exp(0, '0, 1'b1, 2);
        issue_req(0, 1'b1, 16'h0030, '0);
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            step();
        end
        check("wd_rsp", 64'(sb.size()), 64'd0);
        rc0 = rsp_cnt;
        force_done = 1'b1;
        step(); step(); step();
        check("wd_late_done", 64'(rsp_cnt - rc0), 64'd0);
        core_auto = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
